vector_cfu: RTL and testbench

VECTOR_CFU -- requirements
Module: vector_cfu

---
 rtl/vector_cfu_pkg.sv | 31 +++
 rtl/vector_cfu_if.sv | 28 ++
 rtl/vector_cfu_lane.sv | 15 +
 rtl/vector_cfu.sv | 157 +++++++++++++++
 tb/tb_vector_cfu.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_cfu_pkg.sv
// Shared opcodes, FSM state type and command field positions
// for the vector custom function unit.
package vector_cfu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    localparam logic [2:0] OP_SETVL  = 3'd0;
    localparam logic [2:0] OP_VLD    = 3'd1;
    localparam logic [2:0] OP_VRD    = 3'd2;
    localparam logic [2:0] OP_VADD   = 3'd3;
    localparam logic [2:0] OP_VMUL   = 3'd4;
    localparam logic [2:0] OP_VDOT   = 3'd5;
    localparam logic [2:0] OP_ACCCLR = 3'd6;
    localparam logic [2:0] OP_NOP    = 3'd7;

    localparam int VD_LSB   = 0;
    localparam int VS1_LSB  = 8;
    localparam int VS2_LSB  = 16;
    localparam int RF_W     = 4;
    localparam int WREG_LSB = 0;
    localparam int WSEL_LSB = 4;

    function automatic logic is_vec_op(input logic [2:0] op);
        return (op == OP_VADD) || (op == OP_VMUL) || (op == OP_VDOT);
    endfunction

endpackage

// File: rtl/vector_cfu_if.sv
// CFU command/response handshake bundle; master is the CPU side,
// slave is the function unit.
interface vector_cfu_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id,
        output cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id,
        input  cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

endinterface

// File: rtl/vector_cfu_lane.sv
// One element slice: wrapping byte add, low-byte product and
// signed 8x8 product for the dot-product tree.
module vector_cfu_lane (
    input  logic [7:0]         i_a,
    input  logic [7:0]         i_b,
    output logic [7:0]         o_sum,
    output logic [7:0]         o_mul,
    output logic signed [15:0] o_sprod
);

    assign o_sum   = i_a + i_b;
    assign o_mul   = i_a * i_b;
    assign o_sprod = 16'($signed(i_a)) * 16'($signed(i_b));

endmodule

// File: rtl/vector_cfu.sv
// Vector CFU: NREG x VLEN byte register file, LANES elements
// per EXEC cycle, wrapping dot-product accumulator.
module vector_cfu
    import vector_cfu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int VLEN  = 16,
    parameter int NREG  = 8,
    parameter int ACC_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    vector_cfu_if.slave bus
);

    localparam int VL_W = $clog2(VLEN + 1);
    localparam int IX_W = $clog2(VLEN);
    localparam int RI_W = $clog2(NREG);

    state_e r_state, w_next;

    logic [7:0]       r_vreg [NREG][VLEN];
    logic [VL_W-1:0]  r_vl;
    logic [ACC_W-1:0] r_acc;
    logic [31:0]      r_rsp;
    logic [2:0]       r_op;
    logic [RI_W-1:0]  r_vd, r_vs1, r_vs2;
    logic [VL_W-1:0]  r_base;

    logic [2:0]        w_op;
    logic [31:0]       w_in0, w_in1;
    logic              w_cmd_ready, w_rsp_valid, w_accept, w_last;
    logic [RI_W-1:0]   w_vsel;
    logic [IX_W-1:0]   w_wbase;
    logic [31:0]       w_rdword;
    logic [VL_W-1:0]   w_newvl;
    logic [LANES-1:0]  w_act;
    logic [IX_W-1:0]   w_idx [LANES];
    logic [7:0]        w_sum [LANES];
    logic [7:0]        w_mul [LANES];
    logic signed [15:0] w_sprod [LANES];
    logic [ACC_W-1:0]  w_dot, w_acc_nx;
    logic              w_unused;

    assign w_op     = bus.cmd_payload_function_id[2:0];
    assign w_in0    = bus.cmd_payload_inputs_0;
    assign w_in1    = bus.cmd_payload_inputs_1;
    assign w_unused = ^{bus.cmd_payload_function_id[9:3], w_in1[31:8]};
    assign w_accept = w_cmd_ready && bus.cmd_valid;

    assign w_vsel   = RI_W'(32'(w_in1[WREG_LSB +: RF_W]) % NREG);
    assign w_wbase  = IX_W'((32'(w_in1[WSEL_LSB +: RF_W]) % (VLEN / 4)) * 4);
    assign w_rdword = {r_vreg[w_vsel][w_wbase + IX_W'(3)],
                       r_vreg[w_vsel][w_wbase + IX_W'(2)],
                       r_vreg[w_vsel][w_wbase + IX_W'(1)],
                       r_vreg[w_vsel][w_wbase]};
    assign w_newvl  = (w_in0 > 32'(VLEN)) ? VL_W'(VLEN) : VL_W'(w_in0);
    assign w_last   = (r_base + VL_W'(LANES)) >= r_vl;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l] = r_base[IX_W-1:0] + IX_W'(l);
        assign w_act[l] = (r_base + VL_W'(l)) < r_vl;
        vector_cfu_lane u_lane (
            .i_a     (r_vreg[r_vs1][w_idx[l]]),
            .i_b     (r_vreg[r_vs2][w_idx[l]]),
            .o_sum   (w_sum[l]),
            .o_mul   (w_mul[l]),
            .o_sprod (w_sprod[l])
        );
    end

    // Inactive tail lanes of the last group contribute nothing.
    always_comb begin
        w_dot = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_act[l]) w_dot = w_dot + ACC_W'(w_sprod[l]);
        end
    end
    assign w_acc_nx = r_acc + w_dot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid)
                    w_next = (is_vec_op(w_op) && r_vl != '0) ? ST_EXEC : ST_RESP;
            end
            ST_EXEC: if (w_last) w_next = ST_RESP;
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready             = w_cmd_ready;
    assign bus.rsp_valid             = w_rsp_valid;
    assign bus.rsp_payload_outputs_0 = r_rsp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++)
                for (int e = 0; e < VLEN; e++)
                    r_vreg[r][e] <= '0;
            r_vl   <= VL_W'(VLEN);
            r_acc  <= '0;
            r_rsp  <= '0;
            r_op   <= '0;
            r_vd   <= '0;
            r_vs1  <= '0;
            r_vs2  <= '0;
            r_base <= '0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_vd   <= RI_W'(32'(w_in0[VD_LSB +: RF_W]) % NREG);
            r_vs1  <= RI_W'(32'(w_in0[VS1_LSB +: RF_W]) % NREG);
            r_vs2  <= RI_W'(32'(w_in0[VS2_LSB +: RF_W]) % NREG);
            r_base <= '0;
            r_rsp  <= '0;
            case (w_op)
                OP_SETVL: begin
                    r_vl  <= w_newvl;
                    r_rsp <= 32'(w_newvl);
                end
                OP_VLD: begin
                    for (int b = 0; b < 4; b++)
                        r_vreg[w_vsel][w_wbase + IX_W'(b)] <= w_in0[8*b +: 8];
                end
                OP_VRD:    r_rsp <= w_rdword;
                OP_VDOT:   r_rsp <= 32'($signed(r_acc));
                OP_ACCCLR: r_acc <= ACC_W'($signed(w_in0));
                OP_NOP:    r_rsp <= '1;
                default:   r_rsp <= '0;
            endcase
        end else if (r_state == ST_EXEC) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_act[l] && r_op == OP_VADD) r_vreg[r_vd][w_idx[l]] <= w_sum[l];
                if (w_act[l] && r_op == OP_VMUL) r_vreg[r_vd][w_idx[l]] <= w_mul[l];
            end
            if (r_op == OP_VDOT) begin
                r_acc <= w_acc_nx;
                r_rsp <= 32'($signed(w_acc_nx));
            end
            r_base <= r_base + VL_W'(LANES);
        end
    end

endmodule

// File: tb/tb_vector_cfu.sv
// Scoreboard bench for vector_cfu: expected responses queued at
// issue, popped and compared when the response handshake completes.
module tb_vector_cfu;
    import vector_cfu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vector_cfu_if bus ();

    vector_cfu #(.LANES(4), .VLEN(16), .NREG(8), .ACC_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] got, exp;
    int lat;

    task automatic xact(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e,
                        output logic [31:0] r, output int l);
        int n;
        q.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = {7'h5A, op};
        bus.cmd_payload_inputs_0 = a;
        bus.cmd_payload_inputs_1 = b;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_payload_function_id = 10'h3FF;
        bus.cmd_payload_inputs_0 = '1;
        bus.cmd_payload_inputs_1 = '1;
        l = 0;
        while (!bus.rsp_valid && l < 64) begin
            @(negedge clk);
            l++;
        end
        r = bus.rsp_valid ? bus.rsp_payload_outputs_0 : 'x;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.cmd_payload_function_id = '0;
        bus.cmd_payload_inputs_0 = '0;
        bus.cmd_payload_inputs_1 = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_payload_outputs_0 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rsp: valid %b payload %h want 0 0",
                     bus.rsp_valid, bus.rsp_payload_outputs_0);
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        end
        xact(OP_VRD, 32'h0, 32'h00, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_vreg: got %h want %h", got, exp); end
    endtask

    task automatic test_setvl();
        xact(OP_SETVL, 32'd100, 32'h0, 32'd16, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL setvl_100: got %h want %h", got, exp); end
        n_vec++;
        if (lat != 0) begin n_err++; $display("FAIL setvl_lat: got %0d want 0", lat); end
        xact(OP_SETVL, 32'd5, 32'h0, 32'd5, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL setvl_5: got %h want %h", got, exp); end
    endtask

    task automatic test_vadd();
        logic [31:0] ins [4] = '{32'h04030201, 32'h0A0A0A0A, 32'h11223344, 32'h4};
        logic [31:0] adr [4] = '{32'h01, 32'h02, 32'h5A, 32'h0};
        logic [2:0]  ops [4] = '{OP_VLD, OP_VLD, OP_VLD, OP_SETVL};
        logic [31:0] exs [4] = '{32'h0, 32'h0, 32'h0, 32'h4};
        for (int i = 0; i < 4; i++) begin
            xact(ops[i], ins[i], adr[i], exs[i], got, lat);
            exp = q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL vadd_setup%0d: got %h want %h", i, got, exp); end
        end
        xact(OP_VRD, 32'h0, 32'h12, 32'h11223344, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vld_modulo: got %h want %h", got, exp); end
        xact(OP_VADD, 32'h00020103, 32'h0, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vadd_rsp: got %h want %h", got, exp); end
        n_vec++;
        if (lat != 1) begin n_err++; $display("FAIL vadd_lat: got %0d want 1", lat); end
        xact(OP_VRD, 32'h0, 32'h03, 32'h0E0D0C0B, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vadd_w0: got %h want %h", got, exp); end
        xact(OP_VRD, 32'h0, 32'h13, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vadd_w1: got %h want %h", got, exp); end
    endtask

    task automatic test_vdot();
        for (int w = 0; w < 4; w++) begin
            xact(OP_VLD, 32'hFFFFFFFF, 32'((w << 4) | 1), 32'h0, got, lat);
            exp = q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL vdot_ld1_%0d: got %h want %h", w, got, exp); end
            xact(OP_VLD, 32'h02020202, 32'((w << 4) | 2), 32'h0, got, lat);
            exp = q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL vdot_ld2_%0d: got %h want %h", w, got, exp); end
        end
        xact(OP_SETVL, 32'd6, 32'h0, 32'd6, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vdot_setvl: got %h want %h", got, exp); end
        xact(OP_ACCCLR, 32'd10, 32'h0, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL accclr: got %h want %h", got, exp); end
        xact(OP_VDOT, 32'h00020100, 32'h0, 32'hFFFFFFFE, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vdot_1: got %h want %h", got, exp); end
        n_vec++;
        if (lat != 2) begin n_err++; $display("FAIL vdot_lat: got %0d want 2", lat); end
        xact(OP_VDOT, 32'h00020100, 32'h0, 32'hFFFFFFF2, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vdot_2: got %h want %h", got, exp); end
        xact(OP_VMUL, 32'h00020104, 32'h0, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vmul_rsp: got %h want %h", got, exp); end
        xact(OP_VRD, 32'h0, 32'h04, 32'hFEFEFEFE, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vmul_w0: got %h want %h", got, exp); end
        xact(OP_VRD, 32'h0, 32'h14, 32'h0000FEFE, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vmul_tail: got %h want %h", got, exp); end
        xact(OP_VADD, 32'h00020109, 32'h0, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL alias_rsp: got %h want %h", got, exp); end
        xact(OP_VRD, 32'h0, 32'h01, 32'h01010101, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL alias_w0: got %h want %h", got, exp); end
        xact(OP_VRD, 32'h0, 32'h11, 32'hFFFF0101, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL alias_w1: got %h want %h", got, exp); end
    endtask

    task automatic test_vl0();
        xact(OP_SETVL, 32'd0, 32'h0, 32'd0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vl0_setvl: got %h want %h", got, exp); end
        xact(OP_VMUL, 32'h00020103, 32'h0, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vl0_rsp: got %h want %h", got, exp); end
        n_vec++;
        if (lat != 0) begin n_err++; $display("FAIL vl0_lat: got %0d want 0", lat); end
        xact(OP_VRD, 32'h0, 32'h03, 32'h0E0D0C0B, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL vl0_keep: got %h want %h", got, exp); end
        xact(OP_NOP, 32'h12345678, 32'h0, 32'hFFFFFFFF, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL op7: got %h want %h", got, exp); end
    endtask

    task automatic test_backpressure();
        int n;
        q.push_back(32'h0E0D0C0B);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = {7'h0, OP_VRD};
        bus.cmd_payload_inputs_0 = 32'h0;
        bus.cmd_payload_inputs_1 = 32'h03;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_payload_function_id = {7'h0, OP_VLD};
        bus.cmd_payload_inputs_0 = 32'hDEADBEEF;
        bus.cmd_payload_inputs_1 = 32'h05;
        n = 0;
        while (!bus.rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        exp = q.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_payload_outputs_0 !== exp ||
                bus.cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: valid %b payload %h ready %b want 1 %h 0",
                         c, bus.rsp_valid, bus.rsp_payload_outputs_0, bus.cmd_ready, exp);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: valid %b ready %b want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        xact(OP_VRD, 32'h0, 32'h05, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL ignored_cmd: got %h want %h", got, exp); end
    endtask

    task automatic test_reset_mid_exec();
        xact(OP_SETVL, 32'd16, 32'h0, 32'd16, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL rst_setvl: got %h want %h", got, exp); end
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = {7'h0, OP_VDOT};
        bus.cmd_payload_inputs_0 = 32'h00020100;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abort: rsp_valid %b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_idle: valid %b ready %b want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        xact(OP_VRD, 32'h0, 32'h01, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL rst_v1: got %h want %h", got, exp); end
        xact(OP_VRD, 32'h0, 32'h14, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL rst_v4: got %h want %h", got, exp); end
        xact(OP_VDOT, 32'h00020100, 32'h0, 32'h0, got, lat);
        exp = q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL rst_acc: got %h want %h", got, exp); end
        n_vec++;
        if (lat != 4) begin n_err++; $display("FAIL rst_vl: exec %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_setvl();
        test_vadd();
        test_vdot();
        test_vl0();
        test_backpressure();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
